wb_region_mux: RTL and testbench
================================

# wb_region_mux

Parametrised Wishbone address-region multiplexer between the v586 core's single master port and NSLV slaves (internal ROM, PSRAM controller, future peripherals). Replaces the fixed two-way ROM/RAM `wb_adr[31:12]` decode in the top level. Each slave has a base/mask region, and the decoded slave stays locked for the whole burst. Unmapped accesses and stalled slaves are terminated with a bus error.

## Interface
Parameters:
- NSLV, 4, number of slave ports (1..8)
- AW, 32, address width
- DW, 32, data width
- BASE, {NSLV*AW{1'b0}}, packed region bases; slave i at [i*AW +: AW]
- MASK, {NSLV*AW{1'b0}}, packed region masks; hit_i = ((m_adr_i & MASK_i) == (BASE_i & MASK_i))
- TMO_CYC, 255, cycles without ack before timeout (1..65535)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- m_adr_i  in  AW  master address
- m_dat_i  in  DW  master write data
- m_sel_i  in  DW/8  byte selects
- m_we_i  in  1  write enable
- m_stb_i  in  1  strobe; also the cycle qualifier
- m_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- m_dat_o  out  DW  read data, muxed from the selected slave
- m_ack_o  out  1  acknowledge
- m_err_o  out  1  bus error, one-cycle pulse
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o  out  AW/DW/DW/8/1/3  broadcast copies of the master signals
- s_stb_o  out  NSLV  per-slave strobe (cyc)
- s_dat_i  in  NSLV*DW  packed slave read data
- s_ack_i  in  NSLV  slave acknowledges
- err_cnt_o  out  8  saturating count of bus errors

## Operation
- FSM states: IDLE, ACTIVE, ERR.
- IDLE, m_stb_i=1:
  - Decode all regions; the lowest-index hit wins on overlap.
  - On a hit: latch sel_idx and go to ACTIVE.
  - On no hit: go to ERR.
- ACTIVE:
  - s_stb_o[sel_idx] = m_stb_i; all other strobes are 0.
  - m_ack_o = s_ack_i[sel_idx]; m_dat_o = s_dat_i[sel_idx].
  - Ack with m_cti_i of 000 or 111 → IDLE.
  - Ack with m_cti_i = 010 → stay in ACTIVE. Address changes during the burst are not re-decoded.
  - m_stb_i falling (master abort) → IDLE. No error is raised.
  - Timeout counter (16 bit) clears on entry to ACTIVE and on every ack, and increments otherwise.
  - When the counter reaches TMO_CYC: m_err_o=1 for one cycle, s_stb_o all 0, go to ERR.
- ERR:
  - Unmapped access: m_err_o pulses in the first ERR cycle.
  - All s_stb_o = 0. Stay in ERR until m_stb_i=0, then go to IDLE.
- err_cnt_o increments on each m_err_o pulse and saturates at 255.
- m_dat_o = 0 outside ACTIVE. m_ack_o never asserts outside ACTIVE.
- Reset: state IDLE; sel_idx=0; counter=0; s_stb_o=0; m_ack_o=0; m_err_o=0; m_dat_o=0; err_cnt_o=0.
  - Broadcast s_* outputs follow the master inputs combinationally.
- Reset asserted mid-burst aborts immediately. No ack or err is issued for the aborted transfer.

## Timing
- Decode is registered: the first access adds one cycle.
  - Cycle 0: m_stb_i seen in IDLE.
  - Cycle 1: s_stb_o[idx] high.
- Slave-to-master path is combinational: a slave ack in cycle n appears on m_ack_o in cycle n.
- Single-cycle-ack slave gives a 2-cycle classic read. A burst of N beats takes N+1 cycles.
- After a transfer ends with m_stb_i still high, one IDLE decode cycle follows before the next access.
- Ack and timeout in the same cycle: ack wins; no error is raised and the counter clears.
- Unmapped access: m_err_o in cycle 1, i.e. 1 cycle after stb.
- Timeout: m_err_o in cycle TMO_CYC+1 after entry to ACTIVE (no acks).

## Configuration
- WB_MUX_TMO_EN:
  - Defined: timeout counter and the ACTIVE→ERR timeout path are built.
  - Undefined: no counter is built; ACTIVE waits indefinitely for ack or stb drop, and m_err_o comes only from unmapped decode.

## Test plan
All scenarios use NSLV=2, BASE0=0x000FF000, MASK0=0xFFFFF000, BASE1=0, MASK1=0, TMO_CYC=8.
- Classic read 0x000FF010, slave 0 acks cycle 2 with data 0xDEADBEEF → s_stb_o=01 from cycle 1, m_dat_o=0xDEADBEEF with m_ack_o in cycle 2, IDLE in cycle 3.
- Read at 0x00001000 → slave 1 selected (s_stb_o=10).
  - With BASE0 also covering this address, slave 0 wins.
- 4-beat burst at 0x00002000, cti 010,010,010,111, slave 1 acks every cycle → 4 acks on cycles 1..4.
  - m_adr_i moved to 0x000FF000 mid-burst → still slave 1; IDLE after the 111 ack.
- MASK1 = 0xFFFFFFFF, BASE1 = 0x10, access at 0x20 → m_err_o pulse in cycle 1, no s_stb_o, err_cnt_o=1.
  - FSM holds ERR until stb drops.
- Slave 1 never acks (WB_MUX_TMO_EN defined) → m_err_o in cycle 9, s_stb_o=00 from then; undefined → s_stb_o stays 10 for 100 cycles with no err.
- rst_i pulsed during beat 2 of a burst → all outputs 0 asynchronously, err_cnt_o=0; a new access after reset decodes normally.

Source files
------------

// File: rtl/wb_region_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_region_mux
// Purpose  : Wishbone base/mask region mux; slave locked per burst, unmapped
//            or stalled accesses end in a bus error. Timeout: WB_MUX_TMO_EN.
// Revision : 1.0
// ============================================================================
module wb_region_mux #(
   parameter int                 NSLV    = 4,
   parameter int                 AW      = 32,
   parameter int                 DW      = 32,
   parameter logic [NSLV*AW-1:0] BASE    = '0,
   parameter logic [NSLV*AW-1:0] MASK    = '0,
   parameter int                 TMO_CYC = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AW-1:0]        m_adr_i,
   input  logic [DW-1:0]        m_dat_i,
   input  logic [DW/8-1:0]      m_sel_i,
   input  logic                 m_we_i,
   input  logic                 m_stb_i,
   input  logic [2:0]           m_cti_i,
   output logic [DW-1:0]        m_dat_o,
   output logic                 m_ack_o,
   output logic                 m_err_o,
   output logic [AW-1:0]        s_adr_o,
   output logic [DW-1:0]        s_dat_o,
   output logic [DW/8-1:0]      s_sel_o,
   output logic                 s_we_o,
   output logic [2:0]           s_cti_o,
   output logic [NSLV-1:0]      s_stb_o,
   input  logic [NSLV*DW-1:0]   s_dat_i,
   input  logic [NSLV-1:0]      s_ack_i,
   output logic [7:0]           err_cnt_o
);

   localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

   localparam logic [1:0] c_s_idle   = 2'd0;
   localparam logic [1:0] c_s_active = 2'd1;
   localparam logic [1:0] c_s_err    = 2'd2;
   localparam logic [2:0] c_cti_incr = 3'b010;

   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic [IW-1:0] r_sel_idx;
   logic [IW-1:0] w_dec_idx;
   logic          w_dec_hit;
   logic          r_dec_err;
   logic [7:0]    r_err_cnt;
   logic          w_ack;
   logic          w_tmo;
   logic [NSLV-1:0] w_hit;
   logic [DW-1:0]   w_sdat [NSLV];

   generate
      for (genvar i = 0; i < NSLV; i++) begin : g_slv
         assign w_hit[i]  = ((m_adr_i & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]));
         assign w_sdat[i] = s_dat_i[i*DW +: DW];
      end
   endgenerate

   // Scan downward so the lowest-index hit is the one left standing.
   always_comb begin
      w_dec_hit = 1'b0;
      w_dec_idx = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_dec_hit = 1'b1;
            w_dec_idx = IW'(i);
         end
      end
   end

   assign w_ack = (r_state == c_s_active) && s_ack_i[r_sel_idx];

`ifdef WB_MUX_TMO_EN
   logic [15:0] r_tmo_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_tmo_cnt <= 16'd0;
      else if (r_state != c_s_active || w_ack)
         r_tmo_cnt <= 16'd0;
      else
         r_tmo_cnt <= r_tmo_cnt + 16'd1;
   end

   // An ack in the expiry cycle wins, and a dropped strobe is an abort, not an error.
   assign w_tmo = (r_state == c_s_active) && m_stb_i && !w_ack && (r_tmo_cnt == 16'(TMO_CYC));
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= c_s_idle;
         r_sel_idx <= '0;
         r_dec_err <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_dec_err <= (r_state == c_s_idle) && m_stb_i && !w_dec_hit;
         if (r_state == c_s_idle && m_stb_i && w_dec_hit)
            r_sel_idx <= w_dec_idx;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_s_idle: begin
            if (m_stb_i)
               w_next = w_dec_hit ? c_s_active : c_s_err;
         end
         c_s_active: begin
            if (!m_stb_i)
               w_next = c_s_idle;
            else if (w_ack)
               w_next = (m_cti_i == c_cti_incr) ? c_s_active : c_s_idle;
            else if (w_tmo)
               w_next = c_s_err;
         end
         c_s_err: begin
            if (!m_stb_i)
               w_next = c_s_idle;
         end
         default: w_next = c_s_idle;
      endcase
   end

   always_comb begin
      s_stb_o = '0;
      m_ack_o = 1'b0;
      m_dat_o = '0;
      m_err_o = 1'b0;
      case (r_state)
         c_s_active: begin
            if (!w_tmo)
               s_stb_o[r_sel_idx] = m_stb_i;
            m_ack_o = w_ack;
            m_dat_o = w_sdat[r_sel_idx];
            m_err_o = w_tmo;
         end
         c_s_err: m_err_o = r_dec_err;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_err_cnt <= 8'd0;
      else if (m_err_o && r_err_cnt != 8'hFF)
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign err_cnt_o = r_err_cnt;
   assign s_adr_o   = m_adr_i;
   assign s_dat_o   = m_dat_i;
   assign s_sel_o   = m_sel_i;
   assign s_we_o    = m_we_i;
   assign s_cti_o   = m_cti_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_region_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_region_mux
// Purpose  : Randomized self-checking bench for wb_region_mux against a
//            transaction-level model of the region map and bus protocol.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wb_region_mux;

   localparam int          TMO = 8;
   localparam logic [63:0] BASE_P = {32'h0000_0000, 32'h000F_F000};
   localparam logic [63:0] MASK_P = {32'hFFF0_0000, 32'hFFFF_F000};
`ifdef WB_MUX_TMO_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] m_adr = '0;
   logic [31:0] m_dat = '0;
   logic [3:0]  m_sel = '0;
   logic        m_we  = 1'b0;
   logic        m_stb = 1'b0;
   logic [2:0]  m_cti = 3'b000;
   logic [31:0] sdat [2];
   logic [1:0]  s_ack = '0;

   logic [31:0] m_dat_o;
   logic        m_ack_o, m_err_o, s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_stb_o;
   logic [7:0]  err_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_ecnt = 0;

   always #5 clk = ~clk;

   wb_region_mux #(
      .NSLV(2), .AW(32), .DW(32), .BASE(BASE_P), .MASK(MASK_P), .TMO_CYC(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_stb_i(m_stb), .m_cti_i(m_cti),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cti_o(s_cti_o), .s_stb_o(s_stb_o),
      .s_dat_i({sdat[1], sdat[0]}), .s_ack_i(s_ack),
      .err_cnt_o(err_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Region map straight from the base/mask rule; lowest index wins.
   function automatic int ref_decode(input logic [31:0] a);
      logic [31:0] b [2];
      logic [31:0] m [2];
      b[0] = 32'h000F_F000; m[0] = 32'hFFFF_F000;
      b[1] = 32'h0000_0000; m[1] = 32'hFFF0_0000;
      for (int i = 0; i < 2; i++)
         if ((a & m[i]) == (b[i] & m[i])) return i;
      return -1;
   endfunction

   function automatic void bump_err();
      if (exp_ecnt < 255) exp_ecnt++;
   endfunction

   task automatic next_cycle();
      @(posedge clk); #1;
      sdat[0] = $urandom;
      sdat[1] = $urandom;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] e_stb, input logic e_ack,
                             input logic e_err, input bit chk_dat, input logic [31:0] e_dat);
      @(negedge clk);
      chk({tag, "_stb"}, s_stb_o, e_stb);
      chk({tag, "_ack"}, m_ack_o, e_ack);
      chk({tag, "_err"}, m_err_o, e_err);
      if (chk_dat) chk({tag, "_dat"}, m_dat_o, e_dat);
   endtask

   // Cycle 0 of an access: master raises stb while the mux sits in IDLE.
   task automatic start_txn(input logic [31:0] adr, input logic [2:0] cti);
      next_cycle();
      m_stb = 1'b1; m_adr = adr; m_cti = cti; s_ack = '0;
      m_we = 1'($urandom); m_dat = $urandom; m_sel = 4'($urandom);
      check_outs("idle", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("bc_adr", s_adr_o, adr);
      chk("bc_misc", {s_dat_o, s_sel_o, s_we_o, s_cti_o}, {m_dat, m_sel, m_we, cti});
   endtask

   task automatic run_txn(input logic [31:0] adr, input int beats, input bit hold, input int fgap);
      int idx, gap;
      logic [1:0] e_stb;
      idx = ref_decode(adr);
      start_txn(adr, (beats > 1) ? 3'b010 : 3'b000);
      if (idx < 0) begin
         next_cycle();
         check_outs("uerr", 2'b00, 1'b0, 1'b1, 1'b1, 32'h0);
         bump_err();
         repeat ($urandom_range(0, 2)) begin
            next_cycle();
            check_outs("uhold", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
         end
         next_cycle();
         m_stb = 1'b0;
         check_outs("udrop", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
      end else begin
         e_stb = 2'b01 << idx;
         for (int b = 0; b < beats; b++) begin
            gap = (fgap >= 0) ? fgap : $urandom_range(0, TMO);
            for (int j = 0; j <= gap; j++) begin
               next_cycle();
               s_ack[idx]   = (j == gap);
               s_ack[1-idx] = 1'($urandom);
               m_cti = (b == beats - 1) ? ((beats > 1) ? 3'b111 : 3'b000) : 3'b010;
               if (b > 0 && j == 0 && $urandom_range(0, 1) == 1) m_adr = $urandom;
               check_outs("beat", e_stb, (j == gap), 1'b0, 1'b1, sdat[idx]);
            end
         end
         next_cycle();
         s_ack = '0;
         if (hold) begin
            m_adr = adr; m_cti = 3'b000;
            check_outs("post_hold", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
            next_cycle();
            m_stb = 1'b0;
            check_outs("post_drop", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
         end else begin
            m_stb = 1'b0;
            check_outs("post", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
         end
      end
      chk("ecnt", err_cnt_o, 64'(exp_ecnt));
   endtask

   task automatic stall_txn(input logic [31:0] adr);
      int idx;
      logic [1:0] e_stb;
      idx = ref_decode(adr);
      e_stb = 2'b01 << idx;
      start_txn(adr, 3'b000);
      if (TMO_EN) begin
         for (int j = 0; j <= TMO; j++) begin
            next_cycle();
            if (j < TMO) check_outs("twait", e_stb, 1'b0, 1'b0, 1'b1, sdat[idx]);
            else         check_outs("tmo", 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
         end
         bump_err();
         repeat (2) begin
            next_cycle();
            check_outs("terr", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
         end
      end else begin
         for (int j = 0; j < 100; j++) begin
            next_cycle();
            check_outs("nowait", e_stb, 1'b0, 1'b0, 1'b0, 32'h0);
         end
      end
      next_cycle();
      m_stb = 1'b0;
      check_outs("sdrop", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
      chk("s_ecnt", err_cnt_o, 64'(exp_ecnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      sdat[0] = '0; sdat[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {s_stb_o, m_ack_o, m_err_o, m_dat_o, err_cnt_o}, 64'h0);
      rst = 1'b0;

      run_txn(32'h000F_F010, 1, 1'b0, 1);   // slave 0, ack in cycle 2
      run_txn(32'h0000_1000, 1, 1'b0, 0);   // slave 1
      run_txn(32'h000F_F800, 1, 1'b0, 0);   // overlap: slave 0 wins
      run_txn(32'h0000_2000, 4, 1'b0, 0);   // 4-beat burst, slave 1
      run_txn(32'h1234_0020, 1, 1'b0, 0);   // unmapped
      run_txn(32'h0000_3000, 2, 1'b1, TMO); // ack exactly at the timeout limit

      // Master abort: stb drops while waiting for ack, no error.
      start_txn(32'h000F_F100, 3'b000);
      repeat (2) begin
         next_cycle();
         check_outs("abwait", 2'b01, 1'b0, 1'b0, 1'b1, sdat[0]);
      end
      next_cycle();
      m_stb = 1'b0;
      check_outs("abort", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
      check_outs("abidle", 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("ab_ecnt", err_cnt_o, 64'(exp_ecnt));

      stall_txn(32'h0000_4000);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0:       a = {20'h000FF, 12'($urandom)};
            1:       a = {12'h000, 20'($urandom)};
            default: a = $urandom;
         endcase
         run_txn(a, $urandom_range(1, 4), 1'($urandom), -1);
      end

      // Drive the error counter into saturation.
      for (int t = 0; t < 260; t++) begin
         next_cycle(); m_stb = 1'b1; m_adr = 32'hABC0_0000; m_cti = 3'b000;
         next_cycle();
         next_cycle(); m_stb = 1'b0;
         bump_err();
      end
      next_cycle();
      chk("sat_ecnt", err_cnt_o, 64'(exp_ecnt));

      // Asynchronous reset during beat 2 of a burst.
      start_txn(32'h0000_2000, 3'b010);
      next_cycle();
      s_ack = 2'b10;
      check_outs("rb1", 2'b10, 1'b1, 1'b0, 1'b1, sdat[1]);
      next_cycle();
      s_ack = 2'b00;
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {s_stb_o, m_ack_o, m_err_o, m_dat_o}, 64'h0);
      chk("rst_ecnt", err_cnt_o, 64'h0);
      exp_ecnt = 0;
      m_stb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_txn(32'h000F_F020, 1, 1'b0, 0);
      run_txn(32'h0000_5000, 3, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
